// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor
//   Bit-serial ripple subtractor computing d = x - y - bin (modulo 2^WIDTH),
//   one full-subtractor bit per clock, LSB first. One operation in flight.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   in_valid   x/y/bin valid             in_ready   operands can be accepted (IDLE only)
//   x          minuend                   y          subtrahend
//   bin        borrow in
//   out_valid  result valid (DONE)       out_ready  consumer takes result
//   d          difference                bout       borrow out (unsigned x < y + bin)
//   ovf        signed overflow           busy       high in RUN or DONE
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-1:0] d_sh;
  logic             b;

  logic             accept;
  logic             d_bit;
  logic             b_nxt;

  function automatic logic sub_diff(input logic xi, input logic yi, input logic bi);
    return xi ^ yi ^ bi;
  endfunction

  function automatic logic sub_borrow(input logic xi, input logic yi, input logic bi);
    return (~xi & yi) | (~(xi ^ yi) & bi);
  endfunction

  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Current bit: the shift registers always present bit 'cnt' at position 0.
  assign d_bit = sub_diff(x_sh[0], y_sh[0], b);
  assign b_nxt = sub_borrow(x_sh[0], y_sh[0], b);

  // Datapath shift registers: loaded only on acceptance, so inputs outside
  // a valid handshake never reach state.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_sh <= x;
      y_sh <= y;
      b    <= bin;
    end else if (state == RUN) begin
      x_sh <= x_sh >> 1;
      y_sh <= y_sh >> 1;
      d_sh <= {d_bit, d_sh[WIDTH-1:1]};
      b    <= b_nxt;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // On the last bit x_sh[0]/y_sh[0] hold the original operand MSBs.
            d     <= {d_bit, d_sh[WIDTH-1:1]};
            bout  <= b_nxt;
            ovf   <= (x_sh[0] ^ y_sh[0]) & (d_bit ^ x_sh[0]);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
module tb_serial_ripple_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x;
  logic [3:0] y;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] d;
  logic       bout;
  logic       ovf;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;

  serial_ripple_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       bin;
    logic [3:0] d;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation with out_ready already high; checks latency and result.
  task automatic run_op(input string name, input logic [3:0] xa, input logic [3:0] ya,
                        input logic ba, input logic [3:0] ed, input logic eb,
                        input logic eo, input logic check_ovf);
    int wt;
    int lat;
    wt = 0;
    while (!in_ready && wt < 20) begin tick(); wt++; end
    chk({name, "_ready"}, 32'(in_ready), 32'd1);
    x = xa; y = ya; bin = ba; in_valid = 1'b1;
    tick();                                   // acceptance edge E0
    in_valid = 1'b0;
    x = 4'($urandom); y = 4'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk({name, "_latency"}, 32'(lat), 32'd4);
    chk({name, "_d"}, 32'(d), 32'(ed));
    chk({name, "_bout"}, 32'(bout), 32'(eb));
    if (check_ovf) chk({name, "_ovf"}, 32'(ovf), 32'(eo));
    tick();                                   // handshake edge (out_ready high)
  endtask

  initial begin
    int sd;
    logic [4:0] wide;
    logic [3:0] h_d;
    logic       h_b;
    logic       h_o;
    int         lat;

    //          x        y        bin   d        bout  ovf
    vecs[0] = '{4'b1011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b1};  // -5 - 4
    vecs[1] = '{4'b1111, 4'b1101, 1'b1, 4'b0001, 1'b0, 1'b0};  // 15-13-1
    vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0};  // 0-0-1
    vecs[3] = '{4'd4,    4'd11,   1'b0, 4'd9,    1'b1, 1'b1};  // 4-11
    vecs[4] = '{4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1};  // 7-(-1)
    vecs[5] = '{4'd5,    4'd5,    1'b0, 4'd0,    1'b0, 1'b0};  // x==y
    vecs[6] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};  // -8-1
    vecs[7] = '{4'd6,    4'd2,    1'b0, 4'd4,    1'b0, 1'b0};  // 6-2

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = 4'd0; y = 4'd0; bin = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven directed vectors
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].bin,
             vecs[i].d, vecs[i].bout, vecs[i].ovf, 1'b1);

    // Backpressure in DONE with a new request held on in_valid
    out_ready = 1'b0;
    x = 4'b1011; y = 4'b0100; bin = 1'b0; in_valid = 1'b1;
    tick();                                   // accepted
    x = 4'd3; y = 4'd1; bin = 1'b0;           // next op, held high throughout
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk("bp_latency", 32'(lat), 32'd4);
    h_d = d; h_b = bout; h_o = ovf;
    chk("bp_d", 32'(h_d), 32'b0111);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold_d%0d", c), 32'(d), 32'b0111);
      chk($sformatf("bp_hold_flags%0d", c), 32'({bout, ovf}), 32'b01);
      chk($sformatf("bp_hold_in_ready%0d", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();                                   // handshake
    chk("bp_after_valid", 32'(out_valid), 32'd0);
    chk("bp_after_in_ready", 32'(in_ready), 32'd1);
    chk("bp_after_d_kept", 32'({d, bout, ovf}), 32'({4'b0111, 1'b0, 1'b1}));
    tick();                                   // held request accepted now
    in_valid = 1'b0;
    chk("held_accept_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk("held_latency", 32'(lat), 32'd4);
    chk("held_d", 32'(d), 32'd2);
    tick();

    // Reset during RUN (before bit 2 is processed)
    x = 4'd9; y = 4'd3; bin = 1'b0; in_valid = 1'b1;
    tick();                                   // E0
    in_valid = 1'b0;
    tick();                                   // E1
    tick();                                   // E2
    rst_n = 1'b0;
    tick();                                   // E3: reset
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 10; c++) begin
        if (out_valid) seen++;
        tick();
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
    end
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_d", 32'(d), 32'd0);
    run_op("post_abort", 4'd6, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1);

    // Exhaustive sweep against an independent arithmetic model
    for (int xi = 0; xi < 16; xi++)
      for (int yi = 0; yi < 16; yi++)
        for (int bi = 0; bi < 2; bi++) begin
          wide = 5'(xi) - 5'(yi) - 5'(bi);
          sd = $signed(4'(xi)) - $signed(4'(yi)) - bi;
          run_op($sformatf("sw_%0d_%0d_%0d", xi, yi, bi), 4'(xi), 4'(yi), 1'(bi),
                 wide[3:0], wide[4], 1'((sd > 7) || (sd < -8)), 1'b1);
        end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
